// File: rtl/lsu_byte_sequencer_pkg.sv
// Shared funct3 codes, FSM state encoding and request-decode helpers for the byte-wide LSU.
package lsu_byte_sequencer_pkg;

  localparam logic [2:0] F3_LB_SB = 3'b000;
  localparam logic [2:0] F3_LH_SH = 3'b001;
  localparam logic [2:0] F3_LW_SW = 3'b010;
  localparam logic [2:0] F3_LBU   = 3'b100;
  localparam logic [2:0] F3_LHU   = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_XFER = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // Index of the last byte of the access; funct3[1:0] encodes the size for every legal code.
  function automatic logic [1:0] last_idx(input logic [2:0] func3);
    case (func3[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic func3_legal(input logic we, input logic [2:0] func3);
    if (we)
      return (func3 == F3_LB_SB) || (func3 == F3_LH_SH) || (func3 == F3_LW_SW);
    return (func3 == F3_LB_SB) || (func3 == F3_LH_SH) || (func3 == F3_LW_SW) ||
           (func3 == F3_LBU) || (func3 == F3_LHU);
  endfunction

  function automatic logic misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
    return ((func3[1:0] == 2'b01) && addr_lo[0]) ||
           ((func3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_byte_sequencer_load_extend.sv
// Combinational load-data extension: sign/zero extends the byte-assembled word per funct3.
module load_extend
  import lsu_byte_sequencer_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [31:0] word,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = word;
    case (func3)
      F3_LB_SB: rdata = {{24{word[7]}}, word[7:0]};
      F3_LH_SH: rdata = {{16{word[15]}}, word[15:0]};
      F3_LBU:   rdata = {24'd0, word[7:0]};
      F3_LHU:   rdata = {16'd0, word[15:0]};
      default:  rdata = word;
    endcase
  end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Byte-serial load/store sequencer between the MEM stage and a byte-wide req/ack memory port.
// Optional build macro MISALIGN_TRAP_EN: misaligned halfword/word accesses complete with resp_err.
//
// state    | meaning
// LSU_IDLE | req_ready=1, waiting for a request
// LSU_XFER | issuing byte transactions, one per mem_ack
// LSU_DONE | one-cycle response (resp_valid)
module lsu_byte_sequencer
  import lsu_byte_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic              we_q, we_d;
  logic [2:0]        func3_q, func3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       ext_rdata;
  logic              req_bad;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_W];

`ifdef MISALIGN_TRAP_EN
  assign req_bad = !func3_legal(req_we, req_func3) || misaligned(req_func3, req_addr[1:0]);
`else
  assign req_bad = !func3_legal(req_we, req_func3);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      idx_q   <= 2'd0;
      we_q    <= 1'b0;
      func3_q <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    func3_d = func3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          func3_d = req_func3;
          addr_d  = req_addr[ADDR_W-1:0];
          wdata_d = req_wdata;
          idx_d   = 2'd0;
          rdata_d = 32'd0;
          err_d   = req_bad;
          state_d = req_bad ? LSU_DONE : LSU_XFER;
        end
      end
      LSU_XFER: begin
        if (mem_ack) begin
          if (!we_q)
            rdata_d[8*idx_q +: 8] = mem_rdata;
          idx_d = 2'(idx_q + 2'd1);
          if (idx_q == last_idx(func3_q))
            state_d = LSU_DONE;
        end
      end
      LSU_DONE: begin
        idx_d   = 2'd0;
        state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  load_extend u_load_extend (
    .func3 (func3_q),
    .word  (rdata_q),
    .rdata (ext_rdata)
  );

  // Outputs are gated by state so every one of them is 0 in IDLE, except req_ready.
  always_comb begin
    req_ready  = (state_q == LSU_IDLE);
    busy       = (state_q != LSU_IDLE);
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'd0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'd0;
    if (state_q == LSU_XFER) begin
      mem_req   = 1'b1;
      mem_we    = we_q;
      mem_addr  = addr_q + ADDR_W'(idx_q);
      mem_wdata = wdata_q[8*idx_q +: 8];
    end
    if (state_q == LSU_DONE) begin
      resp_valid = 1'b1;
      resp_err   = err_q;
      resp_rdata = (we_q || err_q) ? 32'd0 : ext_rdata;
    end
  end

endmodule
